// File: rtl/uart_buffer_pkg.sv
// Shared constants, status layout and downstream FSM state type for uart_buffer.
package uart_buffer_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] DATA_OFF   = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;

    // STATUS register bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVERRUN  = 4;

    // Uart request strobes
    localparam logic [3:0] UART_WR = 4'b0001;
    localparam logic [3:0] UART_RD = 4'b0000;

    // DATA read value when the RX FIFO has nothing to give (bit31 = empty flag)
    localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_WAIT = 2'd2
    } dn_state_t;

    // Packs the flag bits into the STATUS word; unused bits read 0.
    function automatic logic [31:0] status_word(input logic tx_full, input logic tx_empty,
                                                input logic rx_empty, input logic rx_full,
                                                input logic overrun);
        logic [31:0] w;
        w              = '0;
        w[ST_TX_FULL]  = tx_full;
        w[ST_TX_EMPTY] = tx_empty;
        w[ST_RX_EMPTY] = rx_empty;
        w[ST_RX_FULL]  = rx_full;
        w[ST_OVERRUN]  = overrun;
        return w;
    endfunction

endpackage

// File: rtl/uart_buffer_if.sv
// CPU-side peripheral bus of uart_buffer.
// Handshake: bus_valid is a one-cycle request strobe; the slave answers with a
// one-cycle bus_ready pulse (bus_rdata valid in that cycle). The master issues
// no new request until it has seen bus_ready for the previous one.
interface uart_buffer_if;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (output bus_valid, bus_addr, bus_wdata, bus_wstrb,
                    input  bus_rdata, bus_ready);
    modport slave  (input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
                    output bus_rdata, bus_ready);
endinterface

// File: rtl/uart_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derived from an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy update; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_buffer.sv
// Buffered front-end between the CPU peripheral bus and the uart request port.
module uart_buffer import uart_buffer_pkg::*; #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_buffer_if.slave     bus,
    output logic             uart_valid,
    output logic [31:0]      uart_wdata,
    output logic [3:0]       uart_wstrb,
    input  logic [31:0]      uart_rdata,
    input  logic             uart_ready,
    output dn_state_t        fsm_state
);
    dn_state_t                  state;
    logic [1:0]                 reg_sel;
    logic                       is_write;
    logic                       data_wr, data_rd, status_wr;
    logic                       wr_hold;
    logic [7:0]                 hold_data;
    logic                       overrun;
    logic                       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]                 tx_push_data, tx_head;
    logic [$clog2(TX_DEPTH):0]  tx_count;
    logic                       rx_push, rx_pop, rx_full, rx_empty, rx_done, ovr_set;
    logic [7:0]                 rx_head;
    logic [$clog2(RX_DEPTH):0]  rx_count;
    logic                       unused_bits;

    assign fsm_state = state;
    assign reg_sel   = bus.bus_addr[3:2];
    assign is_write  = |bus.bus_wstrb;
    assign data_wr   = bus.bus_valid && is_write && (reg_sel == DATA_OFF);
    assign data_rd   = bus.bus_valid && !is_write && (reg_sel == DATA_OFF);
    assign status_wr = bus.bus_valid && is_write && (reg_sel == STATUS_OFF);

    assign rx_pop  = data_rd && !rx_empty && !rst;
    assign tx_pop  = (state == IDLE) && !tx_empty && !rst;
    assign rx_done = (state == RX_WAIT) && uart_ready && !rst;
    assign rx_push = rx_done && !rx_full;
    assign ovr_set = rx_done && rx_full;

    assign unused_bits = ^{bus.bus_addr[31:4], bus.bus_addr[1:0], bus.bus_wdata[31:8],
                           uart_rdata[31:8], tx_count, rx_count};

    // TX push source: a held write has priority, since no new request can arrive while one is held
    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = bus.bus_wdata[7:0];
        if (wr_hold) begin
            tx_push      = !tx_full && !rst;
            tx_push_data = hold_data;
        end else if (data_wr) begin
            tx_push = !tx_full && !rst;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_push_data),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (uart_rdata[7:0]),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // CPU side: register decode, one-cycle ready, held DATA write while TX is full, sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
            wr_hold       <= 1'b0;
            hold_data     <= '0;
            overrun       <= 1'b0;
        end else begin
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
            if (wr_hold && !tx_full) begin
                wr_hold       <= 1'b0;
                bus.bus_ready <= 1'b1;
            end
            if (bus.bus_valid) begin
                case (reg_sel)
                    DATA_OFF: begin
                        if (is_write) begin
                            if (tx_full) begin
                                wr_hold   <= 1'b1;
                                hold_data <= bus.bus_wdata[7:0];
                            end else begin
                                bus.bus_ready <= 1'b1;
                            end
                        end else begin
                            bus.bus_ready <= 1'b1;
                            bus.bus_rdata <= rx_empty ? RX_EMPTY_WORD : {24'b0, rx_head};
                        end
                    end
                    STATUS_OFF: begin
                        bus.bus_ready <= 1'b1;
                        if (!is_write)
                            bus.bus_rdata <= status_word(tx_full, tx_empty, rx_empty, rx_full, overrun);
                    end
                    default: bus.bus_ready <= 1'b1;
                endcase
            end
            if (ovr_set)
                overrun <= 1'b1;
            else if (status_wr && bus.bus_wdata[ST_OVERRUN])
                overrun <= 1'b0;
        end
    end

    // Downstream FSM: one uart transaction at a time, TX before RX, waits are never aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            uart_valid <= 1'b0;
            uart_wstrb <= '0;
            uart_wdata <= '0;
        end else begin
            uart_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        uart_valid <= 1'b1;
                        uart_wstrb <= UART_WR;
                        uart_wdata <= {24'b0, tx_head};
                        state      <= TX_WAIT;
                    end else if (!rx_full) begin
                        uart_valid <= 1'b1;
                        uart_wstrb <= UART_RD;
                        uart_wdata <= '0;
                        state      <= RX_WAIT;
                    end
                end
                TX_WAIT: if (uart_ready) state <= IDLE;
                RX_WAIT: if (uart_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buffer.sv
// Directed bench for uart_buffer: register vectors from a table plus uart sequences.
module tb_uart_buffer;
    import uart_buffer_pkg::*;

    logic        clk;
    logic        rst;
    logic        uart_valid;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    dn_state_t   fsm_state;

    uart_buffer_if bif();

    uart_buffer #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .uart_valid (uart_valid),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .fsm_state  (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected uart requests, {wstrb, wdata}
    logic [35:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // uart request monitor against the expected queue
    always @(negedge clk) begin
        if (uart_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL uart_unexpected: got wstrb=%h wdata=%h", uart_wstrb, uart_wdata);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({uart_wstrb, uart_wdata} !== e) begin
                    bad++;
                    $display("FAIL uart_req: got %h want %h", {uart_wstrb, uart_wdata}, e);
                end
            end
        end
    end

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output logic [31:0] rd, output int lat);
        bif.bus_valid = 1'b1;
        bif.bus_addr  = a;
        bif.bus_wdata = wd;
        bif.bus_wstrb = ws;
        @(negedge clk);
        bif.bus_valid = 1'b0;
        bif.bus_wstrb = 4'h0;
        lat = 1;
        while (!bif.bus_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = bif.bus_rdata;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus_xfer(a, 32'h0, 4'h0, rd, lat);
        check({name, "_lat"}, 64'(lat), 64'd1);
        check(name, 64'(rd), 64'(exp));
    endtask

    task automatic wr_do(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus_xfer(a, d, 4'hF, rd, lat);
        check({name, "_lat"}, 64'(lat), 64'd1);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            logic [31:0] rd;
            int lat;
            bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
            if (vecs[i].wstrb == 4'h0)
                check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        end
    endtask

    // wait until all expected uart requests have been seen
    task automatic wait_exp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // complete the outstanding uart transaction, optionally expecting the next request
    task automatic uart_done(input logic [7:0] rbyte, input bit has_next, input logic [35:0] nxt);
        wait_exp("pre_done", 40);
        if (has_next) exp_q.push_back(nxt);
        uart_rdata = {24'hFFFFFF, rbyte};
        uart_ready = 1'b1;
        @(negedge clk);
        uart_ready = 1'b0;
        uart_rdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        bit seen;

        vecs[0]  = '{32'h0000_0004, 32'h0, 4'h0, 32'h0000_0006};
        vecs[1]  = '{32'h0000_0000, 32'h0, 4'h0, 32'h8000_0000};
        vecs[2]  = '{32'h0000_0008, 32'h0, 4'h0, 32'h0000_0000};
        vecs[3]  = '{32'h0000_000C, 32'h0, 4'h0, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[5]  = '{32'h0000_000C, 32'hFFFF_FFFF, 4'h1, 32'h0};
        vecs[6]  = '{32'h0000_0004, 32'h0000_0010, 4'hF, 32'h0};
        vecs[7]  = '{32'h0000_0004, 32'h0, 4'h0, 32'h0000_0006};
        vecs[8]  = '{32'h1234_5674, 32'h0, 4'h0, 32'h0000_0006};
        vecs[9]  = '{32'h0000_0004, 32'h0, 4'h0, 32'h0000_0002};
        vecs[10] = '{32'h0000_0000, 32'h0, 4'h0, 32'h0000_005A};
        vecs[11] = '{32'h0000_0000, 32'h0, 4'h0, 32'h8000_0000};
        vecs[12] = '{32'h0000_0004, 32'h0, 4'h0, 32'h0000_0006};

        rst           = 1'b1;
        bif.bus_valid = 1'b0;
        bif.bus_addr  = 32'h0;
        bif.bus_wdata = 32'h0;
        bif.bus_wstrb = 4'h0;
        uart_rdata    = 32'h0;
        uart_ready    = 1'b0;

        // reset
        @(negedge clk);
        @(negedge clk);
        check("rst_bus", {31'h0, bif.bus_ready, bif.bus_rdata}, 64'h0);
        check("rst_uart", {27'h0, uart_valid, uart_wstrb, uart_wdata}, 64'h0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        exp_q.push_back({UART_RD, 32'h0});
        rst = 1'b0;
        repeat (20) @(negedge clk);
        wait_exp("rst_rx_req", 5);
        check("rst_state_wait", 64'(fsm_state), 64'(RX_WAIT));
        run_vecs(0, 8);

        // RX path
        uart_done(8'h5A, 1'b1, {UART_RD, 32'h0});
        wait_exp("rx_rereq", 10);
        run_vecs(9, 12);

        // TX drain (the pending RX wait completes first)
        wr_do("tx_w41", 32'h0, 32'hFFFF_FF41);
        wr_do("tx_w42", 32'h0, 32'h0000_0042);
        uart_done(8'h11, 1'b1, {UART_WR, 32'h41});
        uart_done(8'h00, 1'b1, {UART_WR, 32'h42});
        uart_done(8'h00, 1'b1, {UART_RD, 32'h0});
        wait_exp("tx_drain", 10);
        rd_check("tx_rx_byte", 32'h0, 32'h0000_0011);

        // TX backpressure: FSM stuck in RX_WAIT, fill TX
        for (int i = 0; i < 16; i++)
            wr_do($sformatf("bp_w%0d", i), 32'h0, 32'h60 + 32'(i));
        rd_check("bp_status_full", 32'h4, 32'h0000_0005);
        bif.bus_valid = 1'b1;
        bif.bus_addr  = 32'h0;
        bif.bus_wdata = 32'h70;
        bif.bus_wstrb = 4'hF;
        @(negedge clk);
        bif.bus_valid = 1'b0;
        bif.bus_wstrb = 4'h0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bif.bus_ready) seen = 1'b1;
            @(negedge clk);
        end
        check("bp_ready_withheld", 64'(seen), 64'd0);
        exp_q.push_back({UART_WR, 32'h60});
        uart_rdata = 32'h0000_0022;
        uart_ready = 1'b1;
        @(negedge clk);
        uart_ready = 1'b0;
        uart_rdata = 32'h0;
        lat = 1;
        while (!bif.bus_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_ready_lat", 64'(lat), 64'd3);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) uart_done(8'h00, 1'b1, {UART_WR, 32'h61 + 32'(i)});
            else        uart_done(8'h00, 1'b1, {UART_RD, 32'h0});
        end
        wait_exp("bp_drain", 10);
        rd_check("bp_rx_byte", 32'h0, 32'h0000_0022);
        rd_check("bp_rx_empty", 32'h0, 32'h8000_0000);

        // RX full
        for (int i = 0; i < 16; i++)
            uart_done(8'h80 + 8'(i), (i < 15), {UART_RD, 32'h0});
        repeat (10) @(negedge clk);
        check("rxf_state", 64'(fsm_state), 64'(IDLE));
        rd_check("rxf_status", 32'h4, 32'h0000_000A);
        exp_q.push_back({UART_RD, 32'h0});
        rd_check("rxf_first", 32'h0, 32'h0000_0080);
        wait_exp("rxf_rereq", 2);
        rd_check("rxf_second", 32'h0, 32'h0000_0081);

        // reset while in TX_WAIT, then a late uart_ready
        wr_do("mid_w33", 32'h0, 32'h33);
        uart_done(8'h44, 1'b1, {UART_WR, 32'h33});
        wait_exp("mid_tx_req", 10);
        check("mid_state_tx", 64'(fsm_state), 64'(TX_WAIT));
        rst = 1'b1;
        exp_q.push_back({UART_RD, 32'h0});
        @(negedge clk);
        check("mid_state_rst", 64'(fsm_state), 64'(IDLE));
        rst        = 1'b0;
        uart_rdata = 32'h0000_0099;
        uart_ready = 1'b1;
        @(negedge clk);
        uart_ready = 1'b0;
        uart_rdata = 32'h0;
        wait_exp("mid_rx_req", 10);
        check("mid_state_wait", 64'(fsm_state), 64'(RX_WAIT));
        rd_check("mid_status", 32'h4, 32'h0000_0006);
        rd_check("mid_data_empty", 32'h0, 32'h8000_0000);

        repeat (5) @(negedge clk);
        check("final_exp_q", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
